// File: rtl/image_mem_arbiter.sv
// Arbitrates the shared image memory between processor load/store and DMA,
// routes processor accesses by address and returns registered read data.
module image_mem_arbiter #(
    parameter int unsigned         DATA_W   = 22,
    parameter int unsigned         PIX_W    = 8,
    parameter logic [DATA_W-1:0]   IMG_BASE = 22'h00_8000,
    parameter int unsigned         MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_adr,
    input  logic [PIX_W-1:0]  dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [PIX_W-1:0]  dma_rdata,
    output logic              dm_we,
    output logic              img_we,
    output logic [DATA_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic [PIX_W-1:0]  img_rdata
);

    typedef enum logic {CPU_PRI, DMA_FORCE} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic        r_pend_cpu, r_pend_dma, r_src_img;

    logic        w_cpu_req, w_cpu_img, w_cpu_data, w_cpu_imgreq;
    logic        w_cpu_acc, w_dma_acc, w_refuse;

    assign w_cpu_req    = cpu_read | cpu_write;
    assign w_cpu_img    = (cpu_adr >= IMG_BASE);
    assign w_cpu_data   = w_cpu_req & ~w_cpu_img;
    assign w_cpu_imgreq = w_cpu_req & w_cpu_img;

    // Data requests always win because mem_adr is shared; they still count as a DMA refusal.
    always_comb begin
        w_cpu_acc = 1'b0;
        w_dma_acc = 1'b0;
        w_refuse  = 1'b0;
        if (w_cpu_data) begin
            w_cpu_acc = 1'b1;
            w_refuse  = dma_req;
        end else if (r_state == DMA_FORCE && dma_req) begin
            w_dma_acc = 1'b1;
        end else if (w_cpu_imgreq) begin
            w_cpu_acc = 1'b1;
            w_refuse  = dma_req;
        end else if (dma_req) begin
            w_dma_acc = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        if (!dma_req || w_dma_acc) begin
            w_state_nxt    = CPU_PRI;
            w_wait_cnt_nxt = '0;
        end else if (w_refuse) begin
            if (r_wait_cnt < MAX_CNT)
                w_wait_cnt_nxt = r_wait_cnt + 4'd1;
            if (w_wait_cnt_nxt >= MAX_CNT)
                w_state_nxt = DMA_FORCE;
        end
    end

    always_comb begin
        cpu_stall = w_cpu_req & ~w_cpu_acc;
        dma_gnt   = w_dma_acc;
        dm_we     = 1'b0;
        img_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        if (w_cpu_acc) begin
            mem_adr = cpu_adr;
            if (cpu_write) begin
                mem_wdata = cpu_wdata;
                dm_we     = reset & ~w_cpu_img;
                img_we    = reset & w_cpu_img;
            end
        end else if (w_dma_acc) begin
            mem_adr = dma_adr;
            if (dma_we) begin
                mem_wdata = {{(DATA_W-PIX_W){1'b0}}, dma_wdata};
                img_we    = reset;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= CPU_PRI;
            r_wait_cnt <= '0;
            r_pend_cpu <= 1'b0;
            r_pend_dma <= 1'b0;
            r_src_img  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_pend_cpu <= w_cpu_acc & cpu_read;
            r_pend_dma <= w_dma_acc & ~dma_we;
            r_src_img  <= w_cpu_acc ? w_cpu_img : 1'b1;
        end
    end

    // Memories register their read data, so the mux below returns a registered value.
    assign cpu_rvalid = r_pend_cpu;
    assign dma_rvalid = r_pend_dma;
    assign cpu_rdata  = !r_pend_cpu ? '0
                      : r_src_img   ? {{(DATA_W-PIX_W){1'b0}}, img_rdata}
                      :               dm_rdata;
    assign dma_rdata  = r_pend_dma ? img_rdata : '0;

endmodule

// File: doc/image_mem_arbiter.md
# image_mem_arbiter

Shares the single-port image memory between the pipelined processor's load/store port and a byte-wide DMA/display port, and routes processor accesses to data memory or image memory by address. It sits between the processor and the `data_memory`/`image_memory` instances. It also drives the processor stall and returns registered read data to whichever requester was served. Data memory is processor-only and never arbitrated.

## Interface
- `DATA_W`, 22: processor data and address width.
- `PIX_W`, 8: image memory word width.
- `IMG_BASE`, 22'h00_8000: first address decoded to image memory; addresses below it go to data memory.
- `MAX_WAIT`, 4: cycles a DMA request may be refused before it is forced through; valid range 1..15.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cpu_read`, `cpu_write`  in  1  processor load/store request; never both high.
- `cpu_adr`  in  DATA_W  processor address.
- `cpu_wdata`  in  DATA_W  store data; image stores use `cpu_wdata[7:0]`.
- `cpu_stall`  out  1  high = processor request not accepted this cycle; hold request stable.
- `cpu_rvalid`  out  1  one-cycle pulse: `cpu_rdata` valid.
- `cpu_rdata`  out  DATA_W  load data; image reads zero-extended to 22 bits.
- `dma_req`  in  1  DMA access request; hold with address and data until granted.
- `dma_we`  in  1  1 = write, 0 = read.
- `dma_adr`  in  DATA_W  image-memory address (DMA never addresses data memory).
- `dma_wdata`  in  PIX_W  DMA write data.
- `dma_gnt`  out  1  DMA request accepted this cycle.
- `dma_rvalid`  out  1  one-cycle pulse: `dma_rdata` valid.
- `dma_rdata`  out  PIX_W  DMA read data.
- `dm_we`, `img_we`  out  1  write enables to data memory and image memory.
- `mem_adr`  out  DATA_W  address shared by both memories.
- `mem_wdata`  out  DATA_W  write data shared by both memories.
- `dm_rdata`  in  DATA_W  data memory read data, registered, one cycle after address.
- `img_rdata`  in  PIX_W  image memory read data, registered, one cycle after address.

## Operation
- Decode: `cpu_img = (cpu_adr >= IMG_BASE)`. A processor request is an image request when `cpu_img` is set, otherwise a data request.
- Processor data requests are accepted immediately (`cpu_stall` = 0) even while DMA holds image memory.
  - In that cycle `mem_adr` carries `cpu_adr`.
  - Image memory sees `img_we` = 0 for the processor.
  - A DMA grant in the same cycle is then deferred, because `mem_adr` is shared. A data request always wins and counts as a refusal.
- FSM states:
  - `CPU_PRI`: processor image request wins over `dma_req`. A refused DMA increments `wait_cnt`. When `wait_cnt` reaches MAX_WAIT, the next state is `DMA_FORCE`.
  - `DMA_FORCE`: the next DMA request is granted over any processor request, which is stalled. After that grant, `wait_cnt` clears and the state returns to `CPU_PRI`.
  - If `dma_req` drops while waiting, `wait_cnt` clears and the state returns to `CPU_PRI`.
- A cycle with no conflict grants whichever requester is present. In `CPU_PRI` a DMA grant clears `wait_cnt`.
- Write enables:
  - Accepted writes assert `dm_we` or `img_we` for exactly the accept cycle.
  - `mem_wdata` = `cpu_wdata` for processor writes and {14'b0, `dma_wdata`} for DMA writes.
- Read return register:
  - On an accepted read, the block latches the owner (cpu/dma) and the source memory (dm/img).
  - Next cycle it pulses the owner's rvalid with the selected data: `cpu_rdata` = `dm_rdata` or {14'b0, `img_rdata`}; `dma_rdata` = `img_rdata`.
- Idle memory outputs: `mem_adr` = 0, `mem_wdata` = 0, both write enables 0.

## Timing
- Reset (`reset` = 0 at an edge): state `CPU_PRI`, `wait_cnt` = 0, pending read cleared. Outputs `cpu_stall` = 0, `cpu_rvalid` = 0, `dma_gnt` = 0, `dma_rvalid` = 0, `cpu_rdata` = 0, `dma_rdata` = 0, `dm_we` = 0, `img_we` = 0.
- Reset asserted the cycle after a read is accepted suppresses that rvalid.
- `cpu_stall` and `dma_gnt` are combinational from the current requests and state. The write enables and `mem_adr` are combinational in the accept cycle.
- Read latency is 1 cycle from acceptance to rvalid, for both requesters. A new access may be accepted in the same cycle an rvalid is returned, giving full back-to-back throughput.
- Worst-case DMA wait is MAX_WAIT+1 cycles after `dma_req` rises, under continuous processor image traffic.
- Worst-case processor stall is 1 cycle per forced DMA grant.
- The `wait_cnt` width is 4 bits and it saturates at MAX_WAIT; no wrap-around.

## Test plan
- Reset low for 2 cycles with every request high → all outputs 0. First cycle after release: `cpu_stall` = 0 for a processor request.
- Processor store to 22'h000010 with data 22'h12345, then load from the same address → `dm_we` pulses 1 cycle, `img_we` stays 0. `cpu_rvalid` arrives the cycle after the load with `cpu_rdata` = 22'h12345.
- Processor store of 8'hA5 to `IMG_BASE`+3, then DMA read of the same address → `dma_gnt` is high in the request cycle, `dma_rvalid` follows next cycle with 8'hA5.
- Continuous processor image loads plus a held `dma_req` with MAX_WAIT = 4 → DMA refused 4 cycles, granted on cycle 5, `cpu_stall` high exactly that cycle, then processor priority resumes.
- Processor data load concurrent with a DMA write → processor accepted, DMA deferred 1 cycle, `img_we` asserted on the following cycle with `dma_wdata`.
- DMA read accepted, then `reset` = 0 on the next edge → no `dma_rvalid`, state `CPU_PRI`, `wait_cnt` = 0.
